// File: rtl/dcm_ramp_scheduler_pkg.sv
// Shared definitions for the DCM ramp scheduler: FSM encoding, multiplier limits,
// and small helpers used when loading registers and the step timer.
package dcm_ramp_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRequest,
    StWaitAck,
    StSettle
  } dcm_state_e;

  localparam int unsigned DCM_MAX_MULT    = 88;
  localparam int unsigned DCM_MIN_MULT    = 2;
  localparam int unsigned DCM_TIMER_WIDTH = 16;

  // Limit a requested multiplier to [lo, hi].
  function automatic logic [7:0] clamp_mult(input logic [7:0]  mult,
                                            input int unsigned lo,
                                            input int unsigned hi);
    logic [7:0] res;
    res = mult;
    if (32'(mult) < lo) begin
      res = 8'(lo);
    end else if (32'(mult) > hi) begin
      res = 8'(hi);
    end
    return res;
  endfunction

  // The timer holds "cycles remaining minus one", so a state that loads N lasts N cycles.
  // Values that do not fit are pinned to the counter maximum instead of wrapping.
  function automatic logic [DCM_TIMER_WIDTH-1:0] timer_load_value(input int unsigned cycles);
    logic [DCM_TIMER_WIDTH-1:0] res;
    if (cycles == 0) begin
      res = '0;
    end else if (cycles > (32'd1 << DCM_TIMER_WIDTH)) begin
      res = '1;
    end else begin
      res = DCM_TIMER_WIDTH'(cycles - 1);
    end
    return res;
  endfunction

endpackage

// File: rtl/dcm_ramp_scheduler_timer.sv
// Loadable 16-bit down-counter that saturates at zero; shared by SETTLE and WAIT_ACK.
module dcm_step_timer
  import dcm_ramp_scheduler_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic [DCM_TIMER_WIDTH-1:0] load_value,
  output logic                       expired
);

  logic [DCM_TIMER_WIDTH-1:0] count;

  // Load has priority; otherwise count down and stick at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - DCM_TIMER_WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/dcm_ramp_scheduler.sv
// DCM multiplier ramp scheduler: walks the programmed multiplier up one step at a time
// with a settle delay after each upward step, jumps straight down, and caps under throttle.
module dcm_ramp_scheduler
  import dcm_ramp_scheduler_pkg::*;
#(
  parameter int unsigned MAXIMUM_MULTIPLIER  = DCM_MAX_MULT,
  parameter int unsigned MINIMUM_MULTIPLIER  = DCM_MIN_MULT,
  parameter int unsigned INITIAL_MULTIPLIER  = 60,
  parameter int unsigned THROTTLE_MULTIPLIER = 20,
  parameter int unsigned SETTLE_CYCLES       = 1024,
  parameter int unsigned ACK_TIMEOUT         = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       host_req,
  input  logic [7:0] host_mult,
  input  logic       throttle,
  output logic       prog_req,
  output logic [7:0] prog_mult,
  input  logic       prog_ack,
  output logic [7:0] current_mult,
  output logic [7:0] target_mult,
  output logic       ramping,
  output logic       prog_timeout
);

  localparam logic [7:0] INIT_MULT = 8'(INITIAL_MULTIPLIER);
  localparam logic [7:0] THR_MULT  = 8'(THROTTLE_MULTIPLIER);
  localparam logic [DCM_TIMER_WIDTH-1:0] ACK_LOAD    = timer_load_value(ACK_TIMEOUT);
  localparam logic [DCM_TIMER_WIDTH-1:0] SETTLE_LOAD = timer_load_value(SETTLE_CYCLES);

  dcm_state_e state, state_next;

  logic [7:0] host_target;
  logic [7:0] next_mult;
  logic [7:0] step_value;
  logic       step_up;
  logic       throttle_q;
  logic       throttle_rise;

  logic                       timer_load;
  logic [DCM_TIMER_WIDTH-1:0] timer_value;
  logic                       timer_expired;

  logic decide;
  logic launch;
  logic ack_ok;
  logic timed_out;

  assign target_mult   = (throttle && (host_target > THR_MULT)) ? THR_MULT : host_target;
  assign step_value    = (target_mult > current_mult) ? current_mult + 8'd1 : target_mult;
  assign throttle_rise = throttle & ~throttle_q;
  assign ramping       = (state != StIdle);

  dcm_step_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (timer_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= StIdle;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and per-state events; ack beats timeout in the expiry cycle.
  always_comb begin
    state_next  = state;
    timer_load  = 1'b0;
    timer_value = '0;
    decide      = 1'b0;
    launch      = 1'b0;
    ack_ok      = 1'b0;
    timed_out   = 1'b0;
    unique case (state)
      StIdle: begin
        if (target_mult != current_mult) begin
          decide     = 1'b1;
          state_next = StRequest;
        end
      end
      StRequest: begin
        launch      = 1'b1;
        timer_load  = 1'b1;
        timer_value = ACK_LOAD;
        state_next  = StWaitAck;
      end
      StWaitAck: begin
        if (prog_ack) begin
          ack_ok = 1'b1;
          if (step_up) begin
            timer_load  = 1'b1;
            timer_value = SETTLE_LOAD;
            state_next  = StSettle;
          end else begin
            state_next = StIdle;
          end
        end else if (timer_expired) begin
          timed_out  = 1'b1;
          state_next = StIdle;
        end
      end
      StSettle: begin
        // A new throttle alarm cuts settling short so the downward jump starts at once.
        if (throttle_rise || timer_expired) begin
          state_next = StIdle;
        end
      end
      default: state_next = StIdle;
    endcase
  end

  // Datapath registers: host target, latched step, handshake outputs and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_target  <= INIT_MULT;
      current_mult <= INIT_MULT;
      prog_req     <= 1'b0;
      prog_mult    <= INIT_MULT;
      prog_timeout <= 1'b0;
      next_mult    <= INIT_MULT;
      step_up      <= 1'b0;
      throttle_q   <= 1'b0;
    end else begin
      throttle_q <= throttle;
      if (host_req) begin
        host_target <= clamp_mult(host_mult, MINIMUM_MULTIPLIER, MAXIMUM_MULTIPLIER);
      end
      // The step is frozen here; later target changes wait for the next IDLE decision.
      if (decide) begin
        next_mult <= step_value;
        step_up   <= (target_mult > current_mult);
      end
      if (launch) begin
        prog_req  <= 1'b1;
        prog_mult <= next_mult;
      end
      if (ack_ok) begin
        prog_req     <= 1'b0;
        current_mult <= next_mult;
      end
      if (timed_out) begin
        prog_req     <= 1'b0;
        prog_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dcm_ramp_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a step-level model.
module tb_dcm_ramp_scheduler;

  localparam int MAXM   = 88;
  localparam int MINM   = 2;
  localparam int INIT   = 60;
  localparam int THR    = 20;
  localparam int SETTLE = 1024;
  localparam int ACKTO  = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       host_req = 1'b0;
  logic [7:0] host_mult = 8'd0;
  logic       throttle = 1'b0;
  logic       prog_ack = 1'b0;
  logic       prog_req;
  logic [7:0] prog_mult;
  logic [7:0] current_mult;
  logic [7:0] target_mult;
  logic       ramping;
  logic       prog_timeout;

  always #5 clk = ~clk;

  dcm_ramp_scheduler #(
    .MAXIMUM_MULTIPLIER  (MAXM),
    .MINIMUM_MULTIPLIER  (MINM),
    .INITIAL_MULTIPLIER  (INIT),
    .THROTTLE_MULTIPLIER (THR),
    .SETTLE_CYCLES       (SETTLE),
    .ACK_TIMEOUT         (ACKTO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host_req     (host_req),
    .host_mult    (host_mult),
    .throttle     (throttle),
    .prog_req     (prog_req),
    .prog_mult    (prog_mult),
    .prog_ack     (prog_ack),
    .current_mult (current_mult),
    .target_mult  (target_mult),
    .ramping      (ramping),
    .prog_timeout (prog_timeout)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 request issued, 2 waiting for ack, 3 settling
  int m_phase, m_cur, m_ht, m_pm, m_nxt, m_cnt;
  bit m_req, m_to, m_up, m_thr;

  function automatic int clampv(input int v);
    return (v < MINM) ? MINM : ((v > MAXM) ? MAXM : v);
  endfunction

  function automatic int eff_target(input int ht, input bit thr);
    return (thr && ht > THR) ? THR : ht;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cur = INIT; m_ht = INIT; m_pm = INIT; m_nxt = INIT; m_cnt = 0;
    m_req = 0; m_to = 0; m_up = 0; m_thr = 0;
  endtask

  task automatic model_step();
    int tgt;
    tgt = eff_target(m_ht, throttle);
    case (m_phase)
      0: if (tgt != m_cur) begin
        m_up = (tgt > m_cur);
        m_nxt = m_up ? m_cur + 1 : tgt;
        m_phase = 1;
      end
      1: begin
        m_req = 1; m_pm = m_nxt; m_cnt = 0; m_phase = 2;
      end
      2: begin
        m_cnt++;
        if (prog_ack) begin
          m_req = 0; m_cur = m_nxt; m_cnt = 0;
          m_phase = m_up ? 3 : 0;
        end else if (m_cnt >= ACKTO) begin
          m_req = 0; m_to = 1; m_phase = 0;
        end
      end
      default: begin
        m_cnt++;
        if ((throttle && !m_thr) || m_cnt >= SETTLE) m_phase = 0;
      end
    endcase
    if (host_req) m_ht = clampv(int'(host_mult));
    m_thr = throttle;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  int exp_tgt;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        exp_tgt = eff_target(m_ht, throttle);
        checks++;
        if (prog_req !== m_req || (m_req && prog_mult !== 8'(m_pm)) ||
            current_mult !== 8'(m_cur) || target_mult !== 8'(exp_tgt) ||
            ramping !== (m_phase != 0) || prog_timeout !== m_to) begin
          failures++;
          $display("FAIL outputs t=%0t got req=%0d mult=%0d cur=%0d tgt=%0d ramp=%0d to=%0d %s",
                   $time, prog_req, prog_mult, current_mult, target_mult, ramping,
                   prog_timeout, $sformatf("expected req=%0d mult=%0d cur=%0d tgt=%0d ramp=%0d to=%0d",
                   m_req, m_pm, m_cur, exp_tgt, m_phase != 0, m_to));
        end
      end
    end
  end

  // ---------------- programmer responder ----------------
  bit ack_en = 1, ack_man = 0, spur_en = 0;
  int ack_min = 0, ack_max = 3, dly = 0;
  int hs_log[$];

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!ack_man) begin
        prog_ack = 1'b0;
        if (!prog_req) begin
          dly = $urandom_range(ack_max, ack_min);
          if (spur_en && $urandom_range(7, 0) == 0) prog_ack = 1'b1;
        end else if (ack_en) begin
          if (dly == 0) begin
            prog_ack = 1'b1;
            hs_log.push_back(int'(prog_mult));
            dly = 1000000;
          end else begin
            dly--;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_host(input int v);
    tick();
    host_req = 1'b1;
    host_mult = 8'(v);
    tick();
    host_req = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    host_req = 1'b0;
    throttle = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic wait_settled(input int budget, input string name);
    int n;
    n = 0;
    while ((ramping || target_mult != current_mult) && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_settled_in_budget"}, n < budget, 1);
  endtask

  task automatic wait_req(input int budget, input string name);
    int n;
    n = 0;
    while (!prog_req && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_req_seen"}, n < budget, 1);
  endtask

  task automatic chk_log(input string name, input int n, input int e0, input int e1, input int e2);
    int exp[3];
    exp[0] = e0; exp[1] = e1; exp[2] = e2;
    chk({name, "_handshakes"}, hs_log.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < hs_log.size()) chk($sformatf("%s_step%0d", name, i), hs_log[i], exp[i]);
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int n;
    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_current", current_mult, 60);
    chk("rst_target", target_mult, 60);
    chk("rst_prog_req", prog_req, 0);
    chk("rst_prog_mult", prog_mult, 60);
    chk("rst_ramping", ramping, 0);
    chk("rst_timeout", prog_timeout, 0);

    // Ramp up 60 -> 63
    hs_log.delete();
    ack_min = 0; ack_max = 4;
    send_host(63);
    wait_settled(5000, "ramp");
    chk_log("ramp", 3, 61, 62, 63);
    chk("ramp_current", current_mult, 63);

    // Clamp high, then clamp low with single downward step
    do_reset();
    send_host(200);
    chk("clamp_high_target", target_mult, 88);
    do_reset();
    hs_log.delete();
    send_host(0);
    chk("clamp_low_target", target_mult, 2);
    wait_settled(200, "clamp_low");
    chk_log("clamp_low", 1, 2, 0, 0);
    chk("clamp_low_current", current_mult, 2);

    // Throttle during settle at 61
    do_reset();
    hs_log.delete();
    send_host(63);
    n = 0;
    while (!(current_mult == 8'd61 && ramping && !prog_req) && n < 200) begin
      tick();
      n++;
    end
    chk("thr_reached_61", n < 200, 1);
    repeat (5) tick();
    throttle = 1'b1;
    tick();
    chk("thr_exit_settle", ramping, 0);
    chk("thr_target", target_mult, 20);
    wait_settled(200, "thr");
    chk_log("thr", 2, 61, 20, 0);
    chk("thr_current", current_mult, 20);

    // Timeout and retry
    do_reset();
    ack_en = 0;
    send_host(61);
    wait_req(20, "to");
    n = 0;
    while (prog_req && n < 5000) begin
      tick();
      n++;
    end
    chk("to_req_cycles", n, 4096);
    chk("to_flag", prog_timeout, 1);
    chk("to_current", current_mult, 60);
    wait_req(20, "to_retry");
    ack_en = 1;
    wait_settled(2000, "to_retry");
    chk("to_retry_current", current_mult, 61);
    chk("to_sticky", prog_timeout, 1);

    // Ack in the very cycle the timeout expires counts as success
    do_reset();
    ack_man = 1;
    prog_ack = 1'b0;
    send_host(61);
    wait_req(20, "edge");
    repeat (4095) tick();
    prog_ack = 1'b1;
    tick();
    prog_ack = 1'b0;
    chk("edge_current", current_mult, 61);
    chk("edge_no_timeout", prog_timeout, 0);
    chk("edge_settling", ramping, 1);
    ack_man = 0;
    wait_settled(2000, "edge");

    // Reset in WAIT_ACK drops prog_req without a clock edge
    do_reset();
    ack_en = 0;
    send_host(62);
    wait_req(20, "rwa");
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rwa_prog_req", prog_req, 0);
    chk("rwa_current", current_mult, 60);
    chk("rwa_ramping", ramping, 0);
    chk("rwa_prog_mult", prog_mult, 60);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    ack_en = 1;

    // Late target change during WAIT_ACK of step 61
    do_reset();
    hs_log.delete();
    ack_min = 20; ack_max = 20;
    send_host(63);
    wait_req(20, "late");
    repeat (3) tick();
    send_host(40);
    wait_settled(3000, "late");
    chk_log("late", 2, 61, 40, 0);
    chk("late_current", current_mult, 40);

    // Random traffic, including stray acks outside WAIT_ACK
    do_reset();
    ack_min = 0; ack_max = 6;
    spur_en = 1;
    for (int c = 0; c < 25000; c++) begin
      tick();
      host_req = 1'b0;
      if ($urandom_range(299, 0) == 0) begin
        host_req = 1'b1;
        host_mult = ($urandom_range(9, 0) < 7) ? 8'($urandom_range(66, 55))
                                                : 8'($urandom_range(255, 0));
      end
      if ($urandom_range(499, 0) == 0) throttle = ~throttle;
    end
    host_req = 1'b0;
    spur_en = 0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
